// File: rtl/mem_pkg.sv
// Shared types for the data-memory load/store front end.
package mem_pkg;

  localparam int unsigned MEM_ADDR_W = 11;
  localparam int unsigned MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LOAD_WAIT = 2'b01,
    ST_RMW_MERGE = 2'b10
  } state_e;

  // Request fields the lane logic still needs after the accept cycle.
  typedef struct packed {
    size_e      size;
    logic       sext;
    logic [1:0] off;
  } req_ctl_t;

  function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = |off;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [MEM_DATA_W-1:0] word,
  input  size_e                 size,
  input  logic                  sext,
  input  logic [1:0]            off,
  input  logic [15:0]           wdata,
  output logic [MEM_DATA_W-1:0] ld_data_c,
  output logic [MEM_DATA_W-1:0] st_data_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{off, 3'b000} +: 8];
    half_lane = off[1] ? word[31:16] : word[15:0];
    ld_data_c = word;
    st_data_c = word;
    case (size)
      SZ_BYTE: begin
        ld_data_c = {{24{sext & byte_lane[7]}}, byte_lane};
        st_data_c[{off, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ld_data_c = {{16{sext & half_lane[15]}}, half_lane};
        st_data_c[{off[1], 4'b0000} +: 16] = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end between EX/MEM and the synchronous-read data RAM.
// Word stores complete in one pass; loads and sub-word stores take a second cycle.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_misalign,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_dout
);

  state_e            state_q, state_d;
  req_ctl_t          ctl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;

  logic              rsp_valid_d, rsp_misalign_d;
  logic [DATA_W-1:0] rsp_rdata_d;

  size_e             req_size_e;
  logic              req_bad;
  logic              accept;
  logic [DATA_W-1:0] ld_data, st_data;

  assign req_size_e = size_e'(req_size);
  assign req_bad    = is_misaligned(req_size_e, req_addr[1:0]);
  assign req_ready  = (state_q == ST_IDLE);
  assign stall      = !req_ready;
  assign accept     = req_valid && req_ready && !rst;

  mem_lane_unit u_lane (
    .word      (ram_dout),
    .size      (ctl_q.size),
    .sext      (ctl_q.sext),
    .off       (ctl_q.off),
    .wdata     (wdata_q),
    .ld_data_c (ld_data),
    .st_data_c (st_data)
  );

  // Next state, RAM drive and response capture.
  always_comb begin
    state_d        = state_q;
    ram_addr       = '0;
    ram_din        = '0;
    ram_wen        = 1'b0;
    rsp_valid_d    = 1'b0;
    rsp_misalign_d = 1'b0;
    rsp_rdata_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_bad) begin
            rsp_valid_d    = 1'b1;
            rsp_misalign_d = 1'b1;
          end else begin
            ram_addr = req_addr[ADDR_W+1:2];
            if (req_we && (req_size_e == SZ_WORD)) begin
              ram_din     = req_wdata;
              ram_wen     = 1'b1;
              rsp_valid_d = 1'b1;
            end else begin
              state_d = req_we ? ST_RMW_MERGE : ST_LOAD_WAIT;
            end
          end
        end
      end
      ST_LOAD_WAIT: begin
        ram_addr    = addr_q;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ld_data;
        state_d     = ST_IDLE;
      end
      ST_RMW_MERGE: begin
        ram_addr    = addr_q;
        ram_din     = st_data;
        ram_wen     = 1'b1;
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset drops any in-flight write in the very cycle it is seen.
    if (rst) begin
      ram_addr = '0;
      ram_din  = '0;
      ram_wen  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched request and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_valid    <= 1'b0;
      rsp_misalign <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      rsp_valid    <= rsp_valid_d;
      rsp_misalign <= rsp_misalign_d;
      rsp_rdata    <= rsp_rdata_d;
      if (accept) begin
        ctl_q   <= '{size: req_size_e, sext: req_signed, off: req_addr[1:0]};
        addr_q  <= req_addr[ADDR_W+1:2];
        wdata_q <= req_wdata[15:0];
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a write-first RAM and a reference model.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, stall, rsp_valid, rsp_misalign, ram_wen;
  logic [31:0] rsp_rdata, ram_din, ram_dout;
  logic [10:0] ram_addr;

  logic        ram_clr;
  logic [31:0] ram     [0:2047];
  logic [31:0] mem_ref [0:2047];
  int          wr_count;
  int          n_checks, n_pass;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_misalign(rsp_misalign), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_wen(ram_wen), .ram_dout(ram_dout)
  );

  // Write-first synchronous-read RAM.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 2048; i++) ram[i] <= '0;
      wr_count <= 0;
    end else if (ram_wen) begin
      ram[ram_addr] <= ram_din;
      ram_dout      <= ram_din;
      wr_count      <= wr_count + 1;
    end else begin
      ram_dout <= ram[ram_addr];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference: expected latency/data/flag, updating the reference memory.
  task automatic ref_op(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [12:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic mis);
    int off, wa;
    logic [31:0] w, mask;
    off = int'(addr[1:0]);
    wa  = int'(addr[12:2]);
    w   = mem_ref[wa];
    rd  = '0;
    mis = 1'b0;
    if (size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)) begin
      mis = 1'b1;
      lat = 1;
    end else if (we) begin
      if (size == 2'd2) begin
        mem_ref[wa] = wd;
        lat = 1;
      end else begin
        mask = (size == 2'd0) ? (32'hFF << (8 * off)) : (32'hFFFF << (8 * off));
        mem_ref[wa] = (w & ~mask) | ((wd << (8 * off)) & mask);
        lat = 2;
      end
    end else begin
      lat = 2;
      if (size == 2'd2) begin
        rd = w;
      end else if (size == 2'd0) begin
        rd = (w >> (8 * off)) & 32'hFF;
        if (sgn && rd[7]) rd = rd | 32'hFFFF_FF00;
      end else begin
        rd = (w >> (8 * off)) & 32'hFFFF;
        if (sgn && rd[15]) rd = rd | 32'hFFFF_0000;
      end
    end
  endtask

  // Present one request, capture accept-cycle RAM drive and the response.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [12:0] addr, input logic [31:0] wd,
                       output logic aw, output logic [10:0] aa, output logic [31:0] ad,
                       output int lat, output logic [31:0] rd, output logic mis, output logic p1);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    #1;
    guard = 0;
    while (!req_ready && guard < 8) begin
      @(negedge clk); #1; guard++;
    end
    aw = ram_wen; aa = ram_addr; ad = ram_din;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = 13'($urandom); req_wdata = $urandom;
    #1;
    lat = -1; rd = '0; mis = 1'b0; p1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (rsp_valid) begin
        lat = c; rd = rsp_rdata; mis = rsp_misalign;
        break;
      end
      @(negedge clk); #1;
    end
    if (lat > 0) begin
      @(negedge clk); #1;
      p1 = !rsp_valid && (rsp_rdata == 32'd0) && !rsp_misalign;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ram_clr = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    ram_clr = 1'b0;
    #1;
    n_checks++; if (ram_wen !== 1'b0) $display("FAIL reset_wen_in_rst: got %b want 0", ram_wen); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_rdata !== 32'd0) $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); else n_pass++;
    n_checks++; if (rsp_misalign !== 1'b0) $display("FAIL reset_misalign: got %b want 0", rsp_misalign); else n_pass++;
    n_checks++; if ({ram_wen, ram_addr, ram_din} !== 44'd0)
      $display("FAIL reset_ram_drive: got wen=%b addr=%h din=%h want all 0", ram_wen, ram_addr, ram_din);
    else n_pass++;
  endtask

  task automatic test_word_path();
    logic aw, mis, p1; logic [10:0] aa; logic [31:0] ad, rd, erd; logic emis; int lat, elat;
    issue(1'b1, SZ_WORD, 1'b0, 13'h010, 32'hDEADBEEF, aw, aa, ad, lat, rd, mis, p1);
    ref_op(1'b1, SZ_WORD, 1'b0, 13'h010, 32'hDEADBEEF, elat, erd, emis);
    n_checks++; if ({aw, aa, ad} !== {1'b1, 11'd4, 32'hDEADBEEF})
      $display("FAIL wstore_accept: got wen=%b addr=%0d din=%h want 1/4/deadbeef", aw, aa, ad);
    else n_pass++;
    n_checks++; if (lat !== 1) $display("FAIL wstore_latency: got %0d want 1", lat); else n_pass++;
    n_checks++; if (p1 !== 1'b1) $display("FAIL wstore_pulse: got %b want 1", p1); else n_pass++;
    issue(1'b0, SZ_WORD, 1'($urandom), 13'h010, $urandom, aw, aa, ad, lat, rd, mis, p1);
    ref_op(1'b0, SZ_WORD, 1'b0, 13'h010, 32'd0, elat, erd, emis);
    n_checks++; if (aw !== 1'b0) $display("FAIL wload_no_write: got %b want 0", aw); else n_pass++;
    n_checks++; if (lat !== 2) $display("FAIL wload_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL wload_data: got %h want deadbeef", rd); else n_pass++;
  endtask

  task automatic test_byte_loads();
    logic aw, mis, p1, emis; logic [10:0] aa; logic [31:0] ad, rd, erd; int lat, elat;
    logic [12:0] addrs [3];
    logic [1:0]  sizes [3];
    logic        sgns  [3];
    logic [31:0] wants [3];
    addrs = '{13'h013, 13'h011, 13'h012};
    sizes = '{SZ_BYTE, SZ_BYTE, SZ_HALF};
    sgns  = '{1'b1, 1'b0, 1'b1};
    wants = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF};
    issue(1'b1, SZ_WORD, 1'b0, 13'h010, 32'h80FF7F01, aw, aa, ad, lat, rd, mis, p1);
    ref_op(1'b1, SZ_WORD, 1'b0, 13'h010, 32'h80FF7F01, elat, erd, emis);
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, sizes[i], sgns[i], addrs[i], $urandom, aw, aa, ad, lat, rd, mis, p1);
      n_checks++; if (rd !== wants[i] || lat !== 2 || mis !== 1'b0)
        $display("FAIL subword_load_%0d: got data=%h lat=%0d mis=%b want %h/2/0", i, rd, lat, mis, wants[i]);
      else n_pass++;
    end
  endtask

  task automatic test_subword();
    logic aw, mis, p1, emis; logic [10:0] aa; logic [31:0] ad, rd, erd; int lat, elat;
    issue(1'b1, SZ_WORD, 1'b0, 13'h010, 32'h11223344, aw, aa, ad, lat, rd, mis, p1);
    ref_op(1'b1, SZ_WORD, 1'b0, 13'h010, 32'h11223344, elat, erd, emis);
    issue(1'b1, SZ_BYTE, 1'b0, 13'h012, {24'($urandom), 8'hAA}, aw, aa, ad, lat, rd, mis, p1);
    ref_op(1'b1, SZ_BYTE, 1'b0, 13'h012, 32'hAA, elat, erd, emis);
    n_checks++; if (aw !== 1'b0) $display("FAIL bstore_read_first: got wen=%b want 0", aw); else n_pass++;
    n_checks++; if (lat !== 2) $display("FAIL bstore_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (ram[4] !== 32'h11AA3344) $display("FAIL bstore_merge: got %h want 11aa3344", ram[4]); else n_pass++;
    issue(1'b1, SZ_HALF, 1'b0, 13'h010, {16'($urandom), 16'hBEEF}, aw, aa, ad, lat, rd, mis, p1);
    ref_op(1'b1, SZ_HALF, 1'b0, 13'h010, 32'hBEEF, elat, erd, emis);
    n_checks++; if (ram[4] !== 32'h11AABEEF) $display("FAIL hstore_merge: got %h want 11aabeef", ram[4]); else n_pass++;
    n_checks++; if (p1 !== 1'b1) $display("FAIL hstore_pulse: got %b want 1", p1); else n_pass++;
  endtask

  task automatic test_misalign();
    logic aw, mis, p1; logic [10:0] aa; logic [31:0] ad, rd; int lat, wc0;
    logic        wes   [3];
    logic [1:0]  sizes [3];
    logic [12:0] addrs [3];
    wes   = '{1'b0, 1'b1, 1'b0};
    sizes = '{SZ_HALF, SZ_WORD, 2'b11};
    addrs = '{13'h011, 13'h012, 13'h010};
    for (int i = 0; i < 3; i++) begin
      wc0 = wr_count;
      issue(wes[i], sizes[i], 1'b1, addrs[i], $urandom, aw, aa, ad, lat, rd, mis, p1);
      n_checks++; if (mis !== 1'b1 || rd !== 32'd0 || lat !== 1)
        $display("FAIL misalign_%0d: got mis=%b data=%h lat=%0d want 1/0/1", i, mis, rd, lat);
      else n_pass++;
      n_checks++; if (wr_count !== wc0) $display("FAIL misalign_nowrite_%0d: got %0d writes want 0", i, wr_count - wc0); else n_pass++;
    end
  endtask

  task automatic test_reset_rmw();
    logic aw, mis, p1, emis; logic [10:0] aa; logic [31:0] ad, rd, erd; int lat, elat, wc0;
    issue(1'b1, SZ_WORD, 1'b0, 13'h010, 32'h11223344, aw, aa, ad, lat, rd, mis, p1);
    ref_op(1'b1, SZ_WORD, 1'b0, 13'h010, 32'h11223344, elat, erd, emis);
    wc0 = wr_count;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_addr = 13'h011; req_wdata = 32'h55;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rmw_rst_accept: got ready=%b want 1", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    #1;
    n_checks++; if (ram_wen !== 1'b0) $display("FAIL rmw_rst_wen: got %b want 0", ram_wen); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL rmw_rst_after: got ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rmw_rst_no_rsp: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (ram[4] !== 32'h11223344 || wr_count !== wc0)
      $display("FAIL rmw_rst_word: got %h writes=%0d want 11223344/0", ram[4], wr_count - wc0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w0, w1, w2, erd; logic emis; int elat, wc0, stall_cnt;
    w0 = $urandom; w1 = $urandom; w2 = $urandom;
    wc0 = wr_count;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_signed = 1'b0; req_addr = 13'h000; req_wdata = w0;
    #1;
    n_checks++; if ({ram_wen, ram_addr} !== {1'b1, 11'd0}) $display("FAIL b2b_first: got wen=%b addr=%0d want 1/0", ram_wen, ram_addr); else n_pass++;
    @(negedge clk);
    req_addr = 13'h004; req_wdata = w1;
    #1;
    n_checks++; if ({req_ready, ram_wen, ram_addr, rsp_valid} !== {1'b1, 1'b1, 11'd1, 1'b1})
      $display("FAIL b2b_second: got ready=%b wen=%b addr=%0d rsp=%b want 1/1/1/1", req_ready, ram_wen, ram_addr, rsp_valid);
    else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || wr_count !== wc0 + 2 || ram[0] !== w0 || ram[1] !== w1)
      $display("FAIL b2b_result: got rsp=%b writes=%0d want 1/2", rsp_valid, wr_count - wc0);
    else n_pass++;
    ref_op(1'b1, SZ_WORD, 1'b0, 13'h000, w0, elat, erd, emis);
    ref_op(1'b1, SZ_WORD, 1'b0, 13'h004, w1, elat, erd, emis);
    // Load then immediately a store held behind it.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_addr = 13'h004;
    @(negedge clk);
    req_we = 1'b1; req_addr = 13'h008; req_wdata = w2;
    #1;
    stall_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (stall) stall_cnt++;
      if (req_ready) break;
      @(negedge clk); #1;
    end
    n_checks++; if (stall_cnt !== 1) $display("FAIL ld_st_stall: got %0d cycles want 1", stall_cnt); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== w1)
      $display("FAIL ld_st_load_rsp: got rsp=%b data=%h want 1/%h", rsp_valid, rsp_rdata, w1);
    else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd0 || ram[2] !== w2)
      $display("FAIL ld_st_store_rsp: got rsp=%b data=%h mem=%h want 1/0/%h", rsp_valid, rsp_rdata, ram[2], w2);
    else n_pass++;
    ref_op(1'b1, SZ_WORD, 1'b0, 13'h008, w2, elat, erd, emis);
  endtask

  task automatic test_random();
    logic we, sgn, aw, mis, p1, emis, ewen; logic [1:0] size; logic [12:0] addr;
    logic [10:0] aa; logic [31:0] wd, ad, rd, erd; int lat, elat;
    for (int i = 0; i < 80; i++) begin
      we   = 1'($urandom_range(0, 1));
      sgn  = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      if (size == 2'd3 && $urandom_range(0, 2) != 0) size = SZ_WORD;
      addr = 13'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      wd   = $urandom;
      issue(we, size, sgn, addr, wd, aw, aa, ad, lat, rd, mis, p1);
      ref_op(we, size, sgn, addr, wd, elat, erd, emis);
      ewen = we && (size == SZ_WORD) && !emis;
      n_checks++; if (lat !== elat || rd !== erd || mis !== emis)
        $display("FAIL rand_%0d: we=%b sz=%0d sg=%b a=%h got lat=%0d d=%h m=%b want %0d/%h/%b",
                 i, we, size, sgn, addr, lat, rd, mis, elat, erd, emis);
      else n_pass++;
      n_checks++; if (aw !== ewen || p1 !== 1'b1)
        $display("FAIL rand_ctl_%0d: got accept_wen=%b pulse=%b want %b/1", i, aw, p1, ewen);
      else n_pass++;
    end
    for (int w = 0; w < 8; w++) begin
      n_checks++; if (ram[w] !== mem_ref[w]) $display("FAIL rand_mem_%0d: got %h want %h", w, ram[w], mem_ref[w]); else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 2048; i++) mem_ref[i] = '0;
    test_reset();
    test_word_path();
    test_byte_loads();
    test_subword();
    test_misalign();
    test_reset_rmw();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
